// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between an instruction-fetch
// requester and a load/store requester. One access at a time. Every access
// goes through the same path: grant, wait for mack (with a timeout), then one
// response cycle that pulses the ready output of the requester that was served.
// The state and all outputs are registered.
//
// Optional feature: define MEM_ARB_RR_EN to break simultaneous fetch/data
// requests in favour of the requester that was not served last. Without it,
// data always wins a tie.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [1:0]  dls,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic [3:0]  mbe,
    input  logic [31:0] mrdata,
    input  logic        mack,
    output logic        merr,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    // Count value seen in the last SERVE cycle before the access is aborted.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } stateT;

    stateT          stateReg;
    stateT          stateNext;
    logic [CW-1:0]  waitCnt;
    logic [CW-1:0]  waitNext;

    logic           pickData;
    logic           serving;
    logic           timeoutHit;
    logic [31:0]    captureWord;
    logic [3:0]     laneBe;
    logic [31:0]    laneData;

    logic           mreqNext;
    logic           mweNext;
    logic [31:0]    maddrNext;
    logic [31:0]    mwdataNext;
    logic [3:0]     mbeNext;
    logic           ireadyNext;
    logic           dreadyNext;
    logic           merrNext;
    logic           busyNext;
    logic [31:0]    irdataNext;
    logic [31:0]    drdataNext;

    // Fetches are always whole aligned words, so the low fetch address bits are dropped.
    logic           unusedBits;
    assign unusedBits = ^iaddr[1:0];

    assign serving     = (stateReg == SERVE_I) || (stateReg == SERVE_D);
    // mack in the same cycle as the last allowed wait wins: the access completes normally.
    assign timeoutHit  = serving && !mack && (waitCnt == WAIT_LAST);
    assign captureWord = mack ? mrdata : 32'h0;

    // Per byte lane: enable and write data for the requested store/load size.
    // Half-word uses daddr[1] only; byte uses daddr[1:0]; size 11 behaves as word.
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        assign laneBe[gi] = (dls == 2'b10) ? (daddr[1:0] == 2'(gi)) :
                            (dls == 2'b01) ? (daddr[1] == (gi >= 2)) : 1'b1;
        assign laneData[8*gi +: 8] = (dls == 2'b10) ? dwdata[7:0] :
                                     (dls == 2'b01) ? dwdata[8*(gi%2) +: 8] :
                                                      dwdata[8*gi +: 8];
    end

`ifdef MEM_ARB_RR_EN
    logic lastGrantData;    // 1 when the most recent grant went to the data port

    // On a tie, grant whichever requester was not served last.
    assign pickData = dreq && (!ireq || !lastGrantData);

    // Remember who received the most recent grant; reset points at fetch so data wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrantData <= 1'b0;
        end else if ((stateReg == IDLE) && (ireq || dreq)) begin
            lastGrantData <= pickData;
        end
    end
`else
    // Fixed priority: data always wins a tie.
    assign pickData = dreq;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            waitCnt  <= '0;
            mreq     <= 1'b0;
            mwe      <= 1'b0;
            maddr    <= 32'h0;
            mwdata   <= 32'h0;
            mbe      <= 4'h0;
            iready   <= 1'b0;
            dready   <= 1'b0;
            merr     <= 1'b0;
            busy     <= 1'b0;
            irdata   <= 32'h0;
            drdata   <= 32'h0;
        end else begin
            stateReg <= stateNext;
            waitCnt  <= waitNext;
            mreq     <= mreqNext;
            mwe      <= mweNext;
            maddr    <= maddrNext;
            mwdata   <= mwdataNext;
            mbe      <= mbeNext;
            iready   <= ireadyNext;
            dready   <= dreadyNext;
            merr     <= merrNext;
            busy     <= busyNext;
            irdata   <= irdataNext;
            drdata   <= drdataNext;
        end
    end

    // Next-state: grant only from IDLE, finish on mack or timeout, one response cycle.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (ireq || dreq) begin
                    stateNext = pickData ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mack || timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output next-values: latch the request on grant, hold it while serving,
    // and on completion capture read data (zero on timeout) and pulse ready.
    always_comb begin
        mreqNext   = (stateNext == SERVE_I) || (stateNext == SERVE_D);
        busyNext   = (stateNext != IDLE);
        mweNext    = mwe;
        maddrNext  = maddr;
        mwdataNext = mwdata;
        mbeNext    = mbe;
        irdataNext = irdata;
        drdataNext = drdata;
        waitNext   = waitCnt;
        ireadyNext = 1'b0;
        dreadyNext = 1'b0;
        merrNext   = 1'b0;

        if ((stateReg == IDLE) && (stateNext == SERVE_I)) begin
            waitNext   = '0;
            mweNext    = 1'b0;
            maddrNext  = {iaddr[31:2], 2'b00};
            mbeNext    = 4'hF;
            mwdataNext = 32'h0;
        end else if ((stateReg == IDLE) && (stateNext == SERVE_D)) begin
            waitNext   = '0;
            mweNext    = dwe;
            maddrNext  = {daddr[31:2], 2'b00};
            mbeNext    = laneBe;
            mwdataNext = laneData;
        end else if (serving) begin
            if (!mack) begin
                waitNext = waitCnt + 1'b1;
            end
            if (stateNext == RESP) begin
                mweNext  = 1'b0;
                merrNext = !mack;
                if (stateReg == SERVE_I) begin
                    ireadyNext = 1'b1;
                    irdataNext = captureWord;
                end else begin
                    dreadyNext = 1'b1;
                    drdataNext = captureWord;
                end
            end
        end
    end

endmodule
